// File: rtl/ava_vram_arbiter.sv
// Single-port VRAM arbiter for the AVA graphics unit: scan-out has priority, the CPU
// is forced through after CPU_MAX_WAIT refused cycles, and read data returns one cycle after the grant.
module ava_vram_arbiter #(
    parameter int ADDR_WIDTH   = 17,
    parameter int WORD_COUNT   = 76800,
    parameter int CPU_MAX_WAIT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  vid_req_i,
    input  logic [ADDR_WIDTH-1:0] vid_addr_i,
    output logic                  vid_gnt_o,
    output logic                  vid_rvalid_o,
    output logic [31:0]           vid_rdata_o,

    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [3:0]            cpu_be_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [31:0]           cpu_wdata_i,
    output logic                  cpu_gnt_o,
    output logic                  cpu_rvalid_o,
    output logic [31:0]           cpu_rdata_o,
    output logic                  cpu_err_o,

    output logic                  mem_en_o,
    output logic [3:0]            mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);

    localparam int WAIT_WIDTH = (CPU_MAX_WAIT > 0) ? $clog2(CPU_MAX_WAIT + 1) : 1;
    localparam logic [WAIT_WIDTH-1:0] WAIT_MAX   = WAIT_WIDTH'(CPU_MAX_WAIT);
    localparam logic [ADDR_WIDTH:0]   WORD_LIMIT = (ADDR_WIDTH + 1)'(WORD_COUNT);

    typedef enum logic {
        VIDEO_FIRST,
        FAVOUR_CPU
    } arb_mode_e;

    arb_mode_e             arb_mode;
    logic [WAIT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic                  tag_valid_q, tag_valid_d;
    logic                  tag_cpu_q, tag_cpu_d;
    logic                  tag_err_q, tag_err_d;
    logic                  tag_write_q, tag_write_d;
    logic                  cpu_in_range;
    logic                  cpu_win;
    logic                  vid_win;

    // The wait counter itself is the arbitration state: at its limit the CPU wins.
    always_comb begin
        arb_mode = (wait_cnt_q == WAIT_MAX) ? FAVOUR_CPU : VIDEO_FIRST;
    end

    // Grants are gated while reset is held so every output reads 0 during reset.
    always_comb begin
        cpu_in_range = ({1'b0, cpu_addr_i} < WORD_LIMIT);
        cpu_win      = 1'b0;
        vid_win      = 1'b0;
        if (reset_n) begin
            if (cpu_req_i && (!vid_req_i || arb_mode == FAVOUR_CPU)) begin
                cpu_win = 1'b1;
            end else if (vid_req_i) begin
                vid_win = 1'b1;
            end
        end

        vid_gnt_o   = vid_win;
        cpu_gnt_o   = cpu_win;
        mem_en_o    = 1'b0;
        mem_we_o    = 4'b0000;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (vid_win) begin
            mem_en_o   = 1'b1;
            mem_addr_o = vid_addr_i;
        end else if (cpu_win && cpu_in_range) begin
            mem_en_o    = 1'b1;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
            mem_we_o    = cpu_we_i ? cpu_be_i : 4'b0000;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (cpu_win) begin
            wait_cnt_d = '0;
        end else if (cpu_req_i && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + WAIT_WIDTH'(1);
        end

        tag_valid_d = vid_win | cpu_win;
        tag_cpu_d   = cpu_win;
        tag_err_d   = cpu_win & ~cpu_in_range;
        tag_write_d = cpu_win & cpu_we_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q  <= '0;
            tag_valid_q <= 1'b0;
            tag_cpu_q   <= 1'b0;
            tag_err_q   <= 1'b0;
            tag_write_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            tag_valid_q <= tag_valid_d;
            tag_cpu_q   <= tag_cpu_d;
            tag_err_q   <= tag_err_d;
            tag_write_q <= tag_write_d;
        end
    end

    // Errors and writes carry no data, and the non-owner always sees zero.
    always_comb begin
        vid_rvalid_o = tag_valid_q & ~tag_cpu_q;
        cpu_rvalid_o = tag_valid_q & tag_cpu_q;
        cpu_err_o    = cpu_rvalid_o & tag_err_q;
        vid_rdata_o  = vid_rvalid_o ? mem_rdata_i : 32'h0;
        cpu_rdata_o  = (cpu_rvalid_o && !tag_err_q && !tag_write_q) ? mem_rdata_i : 32'h0;
    end

endmodule
